program_loader: RTL

- Sequences the instruction-fetch stage's memory-load port. Assembles a program from a UART byte stream into 32-bit words and writes them into instruction memory in order from address 0.
- Holds the pipeline disabled while loading, then releases it.
- Sits between the UART receiver and the fetch stage's write-instruction-memory, address, data and enable inputs.

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader_if.sv | 32 +++
 rtl/program_loader_byte_assembler.sv | 48 ++++
 rtl/program_loader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared constants and types for the program loader and its byte assembler.
//   - LOADER_PC_BITS / LOADER_INSTRUCTION_BITS: default address and word widths.
//   - HALT_INSTRUCTION: the halt encoding. It is the default end-of-program marker.
//   - loader_state_t: loader FSM state encodings.
package program_loader_pkg;

  localparam int LOADER_PC_BITS          = 10;
  localparam int LOADER_INSTRUCTION_BITS = 32;

  localparam logic [31:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    LOADER_IDLE  = 3'd0,
    LOADER_LOAD  = 3'd1,
    LOADER_WRITE = 3'd2,
    LOADER_RUN   = 3'd3,
    LOADER_CHECK = 3'd4
  } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if
//   Instruction-memory write bus between the program loader and the fetch stage.
//   - write_inst_mem : one-cycle write strobe
//   - inst_mem_addr  : write address (PC_BITS wide)
//   - inst_mem_data  : write data (INSTRUCTION_BITS wide)
//   Modports:
//   - master : the loader, which drives the bus
//   - slave  : the fetch stage, which receives it
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int PC_BITS          = LOADER_PC_BITS,
  parameter int INSTRUCTION_BITS = LOADER_INSTRUCTION_BITS
) ();

  logic                        write_inst_mem;
  logic [PC_BITS-1:0]          inst_mem_addr;
  logic [INSTRUCTION_BITS-1:0] inst_mem_data;

  modport master (
    output write_inst_mem,
    output inst_mem_addr,
    output inst_mem_data
  );

  modport slave (
    input write_inst_mem,
    input inst_mem_addr,
    input inst_mem_data
  );

endinterface

// File: rtl/program_loader_byte_assembler.sv
// program_loader_byte_assembler
//   Assembles a big-endian word from a byte stream. The first byte of a word
//   ends up in the most significant byte. It can be reused for data-memory loading.
//   Ports:
//   - clk, rst (async, active low)
//   - clear      : synchronous. Drops any partial word and zeroes the counter.
//   - in_valid   : byte strobe
//   - in_data    : the byte
//   - word       : the word including the byte currently presented. It is
//                  complete whenever word_ready is high.
//   - word_ready : high in the same cycle as the last byte of a word, so the
//                  consumer can register the word at that edge.
//   WORD_BITS must be a multiple of 8 and at least 16.
module program_loader_byte_assembler #(
  parameter int WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_ready
);

  localparam int BYTES = WORD_BITS / 8;
  localparam int CNT_W = $clog2(BYTES);

  logic [WORD_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;

  assign word       = {shift_q[WORD_BITS-9:0], in_data};
  assign word_ready = in_valid && (cnt_q == CNT_W'(BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (in_valid) begin
      shift_q <= word;
      cnt_q   <= word_ready ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Loads a program from a UART byte stream into instruction memory, starting
//   at address 0. The pipeline is held disabled while the program loads. It is
//   released once the END_WORD marker has been written, or once memory is full.
//   Ports:
//   - clk, rst (async, active low)
//   - i_rx_data / i_rx_valid : received byte and its one-cycle strobe
//   - i_restart              : synchronous pulse. Reloads from address 0.
//   - imem (master)          : instruction-memory write bus (strobe/addr/data)
//   - o_enable               : pipeline/PC enable. High only in RUN.
//   - o_loading              : high in LOAD and WRITE
//   - o_overflow             : sticky. Memory filled before END_WORD arrived.
//   - o_word_count           : non-end words written since load start
//   - o_checksum_err         : sticky checksum mismatch (checksum build only)
//   Build option: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing
//   XOR checksum byte after END_WORD before the pipeline is released.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                          PC_BITS          = LOADER_PC_BITS,
  parameter int                          INSTRUCTION_BITS = LOADER_INSTRUCTION_BITS,
  parameter logic [INSTRUCTION_BITS-1:0] END_WORD         = INSTRUCTION_BITS'(HALT_INSTRUCTION)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_restart,
  program_loader_if.master   imem,
  output logic               o_enable,
  output logic               o_loading,
  output logic               o_overflow,
  output logic [PC_BITS-1:0] o_word_count
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  ,
  output logic               o_checksum_err
`endif
);

  localparam logic [PC_BITS-1:0] ADDR_MAX = '1;

  loader_state_t               state_q;
  logic [PC_BITS-1:0]          addr_q;
  logic [INSTRUCTION_BITS-1:0] asm_word;
  logic                        asm_ready;
  logic                        asm_valid;
  logic                        asm_clear;
  logic                        is_end;

  // The registered write data still holds the word being written during WRITE.
  assign is_end = (imem.inst_mem_data == END_WORD);

  // A byte that arrives during WRITE starts the next word. After END_WORD,
  // that byte is not program data: it is either the checksum or ignored.
  assign asm_valid = i_rx_valid && !i_restart &&
                     ((state_q == LOADER_LOAD) || ((state_q == LOADER_WRITE) && !is_end));
  assign asm_clear = i_restart || (state_q == LOADER_IDLE);

  // The address only advances past non-end words and stops at the top of
  // memory. So it doubles as the word count, saturating at 2^PC_BITS-1.
  assign o_word_count = addr_q;

  program_loader_byte_assembler #(
    .WORD_BITS (INSTRUCTION_BITS)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .in_valid   (asm_valid),
    .in_data    (i_rx_data),
    .word       (asm_word),
    .word_ready (asm_ready)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       csum_ok;
  assign csum_ok = (i_rx_data == csum_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= LOADER_IDLE;
      addr_q              <= '0;
      imem.write_inst_mem <= 1'b0;
      imem.inst_mem_addr  <= '0;
      imem.inst_mem_data  <= '0;
      o_enable            <= 1'b0;
      o_loading           <= 1'b0;
      o_overflow          <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q              <= '0;
      o_checksum_err      <= 1'b0;
`endif
    end else if (i_restart) begin
      state_q             <= LOADER_LOAD;
      addr_q              <= '0;
      imem.write_inst_mem <= 1'b0;
      o_enable            <= 1'b0;
      o_loading           <= 1'b1;
      o_overflow          <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q              <= '0;
      o_checksum_err      <= 1'b0;
`endif
    end else begin
      imem.write_inst_mem <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (asm_valid) csum_q <= csum_q ^ i_rx_data;
`endif
      case (state_q)
        LOADER_IDLE: begin
          state_q   <= LOADER_LOAD;
          addr_q    <= '0;
          o_enable  <= 1'b0;
          o_loading <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_q    <= '0;
`endif
        end
        LOADER_LOAD: begin
          if (asm_ready) begin
            state_q             <= LOADER_WRITE;
            imem.write_inst_mem <= 1'b1;
            imem.inst_mem_addr  <= addr_q;
            imem.inst_mem_data  <= asm_word;
          end
        end
        LOADER_WRITE: begin
          if (is_end) begin
            o_loading <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            // The checksum byte may arrive back-to-back, in this very cycle.
            if (i_rx_valid) begin
              if (csum_ok) begin
                state_q  <= LOADER_RUN;
                o_enable <= 1'b1;
              end else begin
                state_q        <= LOADER_IDLE;
                o_checksum_err <= 1'b1;
              end
            end else begin
              state_q <= LOADER_CHECK;
            end
`else
            state_q  <= LOADER_RUN;
            o_enable <= 1'b1;
`endif
          end else if (addr_q == ADDR_MAX) begin
            state_q    <= LOADER_RUN;
            o_overflow <= 1'b1;
            o_enable   <= 1'b1;
            o_loading  <= 1'b0;
          end else begin
            state_q <= LOADER_LOAD;
            addr_q  <= addr_q + 1'b1;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        LOADER_CHECK: begin
          if (i_rx_valid) begin
            if (csum_ok) begin
              state_q  <= LOADER_RUN;
              o_enable <= 1'b1;
            end else begin
              state_q        <= LOADER_IDLE;
              o_checksum_err <= 1'b1;
            end
          end
        end
`endif
        LOADER_RUN: begin
          state_q <= LOADER_RUN;
        end
        default: begin
          state_q <= LOADER_IDLE;
        end
      endcase
    end
  end

endmodule
